// File: rtl/ha_carry_resolve.sv
// ha_carry_resolve: resolves half-adder p/g vectors into an N-bit sum and carry-out,
// rippling CHUNK bits per clock behind a valid/ready handshake.
module ha_carry_resolve #(
    parameter int N     = 4,
    parameter int CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p_in,
    input  logic [N-1:0] g_in,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum_out,
    output logic         cout_out,
    output logic         err
);
    localparam int IW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   p_q, g_q, sum_q;
    logic           carry_q, cout_q, err_q;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CHUNK-1:0] pc, gc, sc;
    logic           c, last;

    if (N % CHUNK != 0) begin : g_chunk_check
        $error("ha_carry_resolve: N must be a multiple of CHUNK");
    end

    // Ripple through the current chunk, lowest bit first.
    always_comb begin
        pc = CHUNK'(p_q >> idx_q);
        gc = CHUNK'(g_q >> idx_q);
        sc = '0;
        c  = carry_q;
        for (int j = 0; j < CHUNK; j++) begin
            sc[j] = pc[j] ^ c;
            c     = gc[j] | (pc[j] & c);
        end
    end

    assign idx_d = idx_q + IW'(CHUNK);
    assign last  = idx_d == IW'(N);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (in_valid ? BUSY : IDLE) :
                  (state_q == BUSY) ? (last ? DONE : BUSY) :
                  (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            g_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == IDLE && in_valid) begin
            p_q     <= p_in;
            g_q     <= g_in;
            carry_q <= cin;
            idx_q   <= '0;
            err_q   <= |(p_in & g_in);
            sum_q   <= '0;
        end else if (state_q == BUSY) begin
            sum_q   <= sum_q | (N'(sc) << idx_q);
            carry_q <= c;
            idx_q   <= idx_d;
            if (last) cout_q <= c;
        end
    end

    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign err      = err_q;
endmodule

// File: tb/tb_ha_carry_resolve.sv
// tb_ha_carry_resolve: directed vector table, corner sequences and randomized
// operands checked against arithmetic / bit-rule reference models.
module tb_ha_carry_resolve;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       iv4, ir4, ov4, or4, cin4, co4, er4;
    logic [3:0] p4, g4, s4;
    logic       iv8, ir8, ov8, or8, cin8, co8, er8;
    logic [7:0] p8, g8, s8;

    ha_carry_resolve #(.N(4), .CHUNK(1)) d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .p_in(p4), .g_in(g4),
        .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum_out(s4), .cout_out(co4), .err(er4)
    );

    ha_carry_resolve #(.N(8), .CHUNK(2)) d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .p_in(p8), .g_in(g8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum_out(s8), .cout_out(co8), .err(er8)
    );

    typedef struct {
        logic [3:0] p, g;
        logic       c;
        logic [3:0] s;
        logic       co, er;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Bit-serial carry rule applied to raw p/g; bit n of the result is the carry-out.
    function automatic logic [8:0] ref_rule(input logic [7:0] p, input logic [7:0] g,
                                            input logic c, input int n);
        logic [8:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        r[n] = c;
        return r;
    endfunction

    task automatic run4(input string nm, input logic [3:0] p, input logic [3:0] g, input logic c,
                        input logic [3:0] es, input logic ec, input logic ee,
                        input int hold, input bit poke);
        int  n = 0;
        bit  busy_ok = 1;
        while (!ir4 && n < 20) begin @(negedge clk); n++; end
        chk({nm, "/ready"}, 32'(ir4), 1);
        p4 = p; g4 = g; cin4 = c; iv4 = 1'b1; or4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin
            if (ir4) busy_ok = 0;
            @(negedge clk);
            n++;
        end
        chk({nm, "/latency"}, 32'(n - 1), 4);
        chk({nm, "/in_ready_busy"}, 32'(busy_ok), 1);
        chk({nm, "/sum"}, 32'(s4), 32'(es));
        chk({nm, "/cout"}, 32'(co4), 32'(ec));
        chk({nm, "/err"}, 32'(er4), 32'(ee));
        if (poke) begin p4 = ~p; g4 = 4'h0; cin4 = ~c; iv4 = 1'b1; end
        repeat (hold) @(negedge clk);
        if (hold > 0)
            chk({nm, "/hold"}, 32'({ov4, ir4, co4, er4, s4}), 32'({1'b1, 1'b0, ec, ee, es}));
        iv4 = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk({nm, "/release"}, 32'({ov4, ir4}), 32'b01);
    endtask

    task automatic run8(input string nm, input logic [7:0] p, input logic [7:0] g, input logic c,
                        input logic [7:0] es, input logic ec, input logic ee);
        int n = 0;
        while (!ir8 && n < 20) begin @(negedge clk); n++; end
        p8 = p; g8 = g; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 20) begin @(negedge clk); n++; end
        chk({nm, "/latency"}, 32'(n - 1), 4);
        chk({nm, "/result"}, 32'({co8, er8, s8}), 32'({ec, ee, es}));
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk({nm, "/release"}, 32'({ov8, ir8}), 32'b01);
    endtask

    initial begin
        logic [3:0] a, b, rp, rg;
        logic [7:0] a8, b8, rp8, rg8;
        logic       rc;
        logic [4:0] t5;
        logic [8:0] t9;
        bit         seen;

        tv[0] = '{4'b0110, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0};
        tv[1] = '{4'b1110, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
        tv[2] = '{4'b0001, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b1};
        tv[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0};
        tv[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tv[5] = '{4'b0000, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0};
        tv[6] = '{4'b1010, 4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0};

        rst = 1'b1;
        iv4 = 0; or4 = 0; p4 = 0; g4 = 0; cin4 = 0;
        iv8 = 0; or8 = 0; p8 = 0; g8 = 0; cin8 = 0;
        repeat (2) @(negedge clk);
        chk("reset4", 32'({ir4, ov4, co4, er4, s4}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
        chk("reset8", 32'({ir8, ov8, co8, er8, s8}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h0}));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run4($sformatf("vec%0d", i), tv[i].p, tv[i].g, tv[i].c, tv[i].s, tv[i].co, tv[i].er, 0, 0);

        run4("hold", tv[0].p, tv[0].g, tv[0].c, tv[0].s, tv[0].co, tv[0].er, 3, 1);

        // Abort an operation on its second BUSY cycle after a result with cout=1.
        run4("pre_rst", tv[1].p, tv[1].g, tv[1].c, tv[1].s, tv[1].co, tv[1].er, 0, 0);
        p4 = 4'b0001; g4 = 4'b0001; cin4 = 1'b0; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy_reset", 32'({ir4, ov4, co4, er4, s4}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
        rst = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (ov4) seen = 1; end
        chk("no_result_after_reset", 32'(seen), 0);

        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom); b = 4'($urandom); rc = 1'($urandom);
            t5 = 5'(a) + 5'(b) + 5'(rc);
            run4($sformatf("rand%0d", i), a ^ b, a & b, rc, t5[3:0], t5[4], 1'b0,
                 int'($urandom_range(0, 2)), 0);
        end
        for (int i = 0; i < 20; i++) begin
            rp = 4'($urandom); rg = 4'($urandom); rc = 1'($urandom);
            t9 = ref_rule({4'h0, rp}, {4'h0, rg}, rc, 4);
            run4($sformatf("raw%0d", i), rp, rg, rc, t9[3:0], t9[4], |(rp & rg), 1, 0);
        end

        run8("wide_fe", 8'hFE, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); rc = 1'($urandom);
            t9 = 9'(a8) + 9'(b8) + 9'(rc);
            run8($sformatf("wide_rand%0d", i), a8 ^ b8, a8 & b8, rc, t9[7:0], t9[8], 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            rp8 = 8'($urandom); rg8 = 8'($urandom); rc = 1'($urandom);
            t9 = ref_rule(rp8, rg8, rc, 8);
            run8($sformatf("wide_raw%0d", i), rp8, rg8, rc, t9[7:0], t9[8], |(rp8 & rg8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
